// File: rtl/lsu_mem_port.sv
// Load/store memory port: issues aligned accesses directly, splits misaligned H/W into byte accesses.
// Loads respond 1 cycle after the last access; stall holds the requester while a split is in flight.
module lsu_mem_port #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              stall,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              illegal,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_write,
   output logic              mem_read,
   output logic              mem_half,
   output logic              mem_byte,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic {IDLE, SPLIT} state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic              write_q;
   logic [2:0]        funct3_q;
   logic [1:0]        cnt_q;
   logic [1:0]        last_q;
   logic [31:0]       rbuf_q;
   logic              resp_valid_q;
   logic              illegal_q;
   logic [31:0]       resp_rdata_q;

   logic              legal;
   logic              aligned;
   logic [7:0]        wbyte;
   logic [31:0]       rdata_asm_d;

   function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
      case (f3)
         3'b000:  extend = {{24{d[7]}}, d[7:0]};
         3'b001:  extend = {{16{d[15]}}, d[15:0]};
         3'b100:  extend = {24'h0, d[7:0]};
         3'b101:  extend = {16'h0, d[15:0]};
         default: extend = d;
      endcase
   endfunction

   always_comb begin
      legal = 1'b0;
      case (req_funct3)
         3'b000, 3'b001, 3'b010: legal = 1'b1;
         3'b100, 3'b101:         legal = ~req_write;
         default:                legal = 1'b0;
      endcase

      aligned = 1'b0;
      case (req_funct3[1:0])
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = ~req_addr[0];
         default: aligned = (req_addr[1:0] == 2'b00);
      endcase

      wbyte       = wdata_q[7:0];
      rdata_asm_d = rbuf_q;
      case (cnt_q)
         2'd1: begin
            wbyte              = wdata_q[15:8];
            rdata_asm_d[15:8]  = mem_rdata[7:0];
         end
         2'd2: begin
            wbyte              = wdata_q[23:16];
            rdata_asm_d[23:16] = mem_rdata[7:0];
         end
         2'd3: begin
            wbyte              = wdata_q[31:24];
            rdata_asm_d[31:24] = mem_rdata[7:0];
         end
         default: rdata_asm_d[7:0] = mem_rdata[7:0];
      endcase
   end

   // Memory port is combinational so an aligned access completes in its acceptance cycle.
   always_comb begin
      mem_addr  = '0;
      mem_write = 1'b0;
      mem_read  = 1'b0;
      mem_half  = 1'b0;
      mem_byte  = 1'b0;
      mem_wdata = '0;
      stall     = 1'b0;
      if (state_q == IDLE) begin
         if (req_valid && legal) begin
            mem_addr  = req_addr;
            mem_write = req_write;
            mem_read  = ~req_write;
            if (aligned) begin
               mem_half  = (req_funct3[1:0] == 2'b01);
               mem_byte  = (req_funct3[1:0] == 2'b00);
               mem_wdata = req_wdata;
            end else begin
               mem_byte  = 1'b1;
               mem_wdata = {24'h0, req_wdata[7:0]};
               stall     = 1'b1;
            end
         end
      end else begin
         mem_addr  = addr_q + {{(ADDR_W-2){1'b0}}, cnt_q};
         mem_write = write_q;
         mem_read  = ~write_q;
         mem_byte  = 1'b1;
         mem_wdata = {24'h0, wbyte};
         stall     = (cnt_q != last_q);
      end
      // Reset must silence the port at once, even mid-split and between clock edges.
      if (!rst_n) begin
         mem_write = 1'b0;
         mem_read  = 1'b0;
         stall     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         wdata_q      <= '0;
         write_q      <= 1'b0;
         funct3_q     <= 3'b000;
         cnt_q        <= 2'd0;
         last_q       <= 2'd0;
         rbuf_q       <= '0;
         resp_valid_q <= 1'b0;
         illegal_q    <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         resp_valid_q <= 1'b0;
         illegal_q    <= 1'b0;
         if (state_q == IDLE) begin
            if (req_valid) begin
               if (!legal) begin
                  illegal_q <= 1'b1;
               end else if (aligned) begin
                  if (!req_write) begin
                     resp_valid_q <= 1'b1;
                     resp_rdata_q <= extend(req_funct3, mem_rdata);
                  end
               end else begin
                  addr_q   <= req_addr;
                  wdata_q  <= req_wdata;
                  write_q  <= req_write;
                  funct3_q <= req_funct3;
                  cnt_q    <= 2'd1;
                  last_q   <= req_funct3[1] ? 2'd3 : 2'd1;
                  rbuf_q   <= {24'h0, mem_rdata[7:0]};
                  state_q  <= SPLIT;
               end
            end
         end else begin
            rbuf_q <= rdata_asm_d;
            cnt_q  <= cnt_q + 2'd1;
            if (cnt_q == last_q) begin
               state_q <= IDLE;
               if (!write_q) begin
                  resp_valid_q <= 1'b1;
                  resp_rdata_q <= extend(funct3_q, rdata_asm_d);
               end
            end
         end
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign illegal    = illegal_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: byte-array memory, per-request access-sequence model, directed and random requests.
module tb_lsu_mem_port;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        stall, resp_valid, illegal;
   logic [31:0] resp_rdata;
   logic [31:0] mem_addr;
   logic        mem_write, mem_read, mem_half, mem_byte;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int vec  = 0;
   int miss = 0;

   logic        exp_rv = 1'b0;
   logic        exp_ill = 1'b0;
   logic [31:0] exp_rd = '0;

   bit   [7:0]  mem [256];
   logic [31:0] wlog [$];
   logic [7:0]  ra;

   lsu_mem_port #(.ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_write(req_write), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .illegal(illegal),
      .mem_addr(mem_addr), .mem_write(mem_write), .mem_read(mem_read),
      .mem_half(mem_half), .mem_byte(mem_byte), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_write) begin
         mem[mem_addr[7:0]] <= mem_wdata[7:0];
         if (!mem_byte) mem[mem_addr[7:0] + 8'd1] <= mem_wdata[15:8];
         if (!mem_byte && !mem_half) begin
            mem[mem_addr[7:0] + 8'd2] <= mem_wdata[23:16];
            mem[mem_addr[7:0] + 8'd3] <= mem_wdata[31:24];
         end
         wlog.push_back(mem_addr);
      end
   end

   always_comb begin
      ra = mem_addr[7:0];
      mem_rdata = {mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]};
      if (mem_byte) mem_rdata[31:8] = '0;
      else if (mem_half) mem_rdata[31:16] = '0;
   end

   // One request: model derives legality, access count, per-cycle port values and the load result.
   task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
      logic        legal, aligned, ebyte, ehalf, estall;
      int          size, n;
      logic [7:0]  b [4];
      logic [31:0] val, a, ewd;
      legal   = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!w && (f3 == 3'd4 || f3 == 3'd5));
      size    = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
      aligned = ((addr % 32'(size)) == 32'd0);
      n       = (!legal || aligned) ? 1 : size;
      val     = '0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (k == 0) begin
            req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = addr; req_wdata = wd;
            for (int j = 0; j < 4; j++) b[j] = mem[8'(addr + 32'(j))];
            case (f3)
               3'd0:    val = 32'($signed(b[0]));
               3'd4:    val = {24'h0, b[0]};
               3'd1:    val = 32'($signed({b[1], b[0]}));
               3'd5:    val = {16'h0, b[1], b[0]};
               default: val = {b[3], b[2], b[1], b[0]};
            endcase
         end else begin
            req_valid = 1'($urandom); req_write = 1'($urandom); req_funct3 = 3'($urandom);
            req_addr = $urandom; req_wdata = $urandom;
         end
         #1;
         vec++;
         if ({resp_valid, illegal, resp_rdata} !== {exp_rv, exp_ill, exp_rd})
            $display("FAIL resp k=%0d got rv=%b ill=%b rd=%h want rv=%b ill=%b rd=%h",
                     k, resp_valid, illegal, resp_rdata, exp_rv, exp_ill, exp_rd);
         if ({resp_valid, illegal, resp_rdata} !== {exp_rv, exp_ill, exp_rd}) miss++;
         a = addr + 32'(k);
         if (!legal) begin
            vec++;
            if ({mem_read, mem_write} !== 2'b00) begin
               miss++;
               $display("FAIL illegal_noaccess f3=%0d got rd=%b wr=%b want 0 0", f3, mem_read, mem_write);
            end
         end else begin
            ebyte  = aligned ? (size == 1) : 1'b1;
            ehalf  = aligned && (size == 2);
            estall = (k < n - 1);
            vec++;
            if ({mem_read, mem_write, mem_byte, mem_half, stall} !== {!w, w, ebyte, ehalf, estall}) begin
               miss++;
               $display("FAIL ctrl k=%0d f3=%0d addr=%h got rd/wr/b/h/st=%b%b%b%b%b want %b%b%b%b%b",
                        k, f3, addr, mem_read, mem_write, mem_byte, mem_half, stall, !w, w, ebyte, ehalf, estall);
            end
            vec++;
            if (mem_addr !== a) begin
               miss++;
               $display("FAIL mem_addr k=%0d got %h want %h", k, mem_addr, a);
            end
            if (w) begin
               ewd = aligned ? wd : ((wd >> (8 * k)) & 32'hFF);
               vec++;
               if ((aligned ? mem_wdata : {24'h0, mem_wdata[7:0]}) !== ewd) begin
                  miss++;
                  $display("FAIL mem_wdata k=%0d got %h want %h", k, mem_wdata, ewd);
               end
            end
         end
         exp_rv = 1'b0; exp_ill = 1'b0;
         if (k == n - 1) begin
            if (!legal) exp_ill = 1'b1;
            else if (!w) begin exp_rv = 1'b1; exp_rd = val; end
         end
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         req_valid = 1'b0;
         #1;
         vec++;
         if ({resp_valid, illegal, resp_rdata} !== {exp_rv, exp_ill, exp_rd}) begin
            miss++;
            $display("FAIL idle_resp got rv=%b ill=%b rd=%h want rv=%b ill=%b rd=%h",
                     resp_valid, illegal, resp_rdata, exp_rv, exp_ill, exp_rd);
         end
         vec++;
         if ({mem_read, mem_write, stall} !== 3'b000) begin
            miss++;
            $display("FAIL idle_port got rd=%b wr=%b st=%b want 000", mem_read, mem_write, stall);
         end
         exp_rv = 1'b0; exp_ill = 1'b0;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd1; req_addr = 32'h3;
      #2;
      vec++;
      if ({stall, resp_valid, illegal, resp_rdata, mem_write, mem_read} !== 36'h0) begin
         miss++;
         $display("FAIL reset_pre_clk got st=%b rv=%b ill=%b rd=%h wr=%b rdn=%b want all 0",
                  stall, resp_valid, illegal, resp_rdata, mem_write, mem_read);
      end
      @(negedge clk); #1;
      vec++;
      if ({stall, resp_valid, illegal, resp_rdata, mem_write, mem_read} !== 36'h0) begin
         miss++;
         $display("FAIL reset_held got st=%b rv=%b ill=%b rd=%h wr=%b rdn=%b want all 0",
                  stall, resp_valid, illegal, resp_rdata, mem_write, mem_read);
      end
      @(negedge clk);
      rst_n = 1'b1; req_valid = 1'b0;
      exp_rv = 1'b0; exp_ill = 1'b0; exp_rd = '0;
      idle(1);
   endtask

   task automatic test_lb_lbu;
      issue(1'b1, 3'd0, 32'h0, 32'hAB_CD_12_FF);
      issue(1'b0, 3'd0, 32'h0, 32'h0);
      idle(1);
      vec++;
      if (resp_rdata !== 32'hFFFF_FFFF) begin
         miss++; $display("FAIL lb_value got %h want ffffffff", resp_rdata);
      end
      issue(1'b0, 3'd4, 32'h0, 32'h0);
      idle(1);
      vec++;
      if (resp_rdata !== 32'h0000_00FF) begin
         miss++; $display("FAIL lbu_value got %h want 000000ff", resp_rdata);
      end
   endtask

   task automatic test_split_store;
      wlog.delete();
      issue(1'b1, 3'd2, 32'h5, 32'h1122_3344);
      idle(1);
      vec++;
      if (wlog.size() != 4 || wlog[0] !== 32'h5 || wlog[1] !== 32'h6 || wlog[2] !== 32'h7 || wlog[3] !== 32'h8) begin
         miss++; $display("FAIL sw_split_addrs got %0d writes first=%h want 5,6,7,8", wlog.size(), wlog[0]);
      end
      vec++;
      if ({mem[5], mem[6], mem[7], mem[8]} !== 32'h4433_2211) begin
         miss++; $display("FAIL sw_split_data got %h%h%h%h want 44332211", mem[5], mem[6], mem[7], mem[8]);
      end
   endtask

   task automatic test_split_load;
      issue(1'b1, 3'd0, 32'h3, 32'h80);
      issue(1'b1, 3'd0, 32'h4, 32'hFF);
      issue(1'b0, 3'd1, 32'h3, 32'h0);
      idle(1);
      vec++;
      if (resp_rdata !== 32'hFFFF_FF80) begin
         miss++; $display("FAIL lh_split_value got %h want ffffff80", resp_rdata);
      end
   endtask

   task automatic test_illegal;
      issue(1'b0, 3'd3, 32'h0, 32'h0);
      issue(1'b1, 3'd4, 32'h1, 32'h55);
      issue(1'b0, 3'd6, 32'h2, 32'h0);
      issue(1'b1, 3'd7, 32'h3, 32'h0);
      idle(2);
   endtask

   task automatic test_wrap;
      wlog.delete();
      issue(1'b1, 3'd2, 32'hFFFF_FFFE, $urandom);
      idle(1);
      vec++;
      if (wlog.size() != 4 || wlog[0] !== 32'hFFFF_FFFE || wlog[1] !== 32'hFFFF_FFFF ||
          wlog[2] !== 32'h0 || wlog[3] !== 32'h1) begin
         miss++; $display("FAIL wrap_addrs got %0d writes last=%h want fffffffe..1", wlog.size(), wlog[wlog.size()-1]);
      end
   endtask

   task automatic test_reset_mid_split;
      wlog.delete();
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2; req_addr = 32'h5; req_wdata = 32'hA1B2_C3D4;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      vec++;
      if ({stall, resp_valid, illegal, resp_rdata, mem_write, mem_read} !== 36'h0) begin
         miss++;
         $display("FAIL reset_mid_split got st=%b rv=%b ill=%b rd=%h wr=%b rdn=%b want all 0",
                  stall, resp_valid, illegal, resp_rdata, mem_write, mem_read);
      end
      repeat (2) @(posedge clk);
      vec++;
      if (wlog.size() != 2 || wlog[0] !== 32'h5 || wlog[1] !== 32'h6) begin
         miss++; $display("FAIL reset_abort_writes got %0d writes want 2 (5,6)", wlog.size());
      end
      @(negedge clk);
      rst_n = 1'b1;
      exp_rv = 1'b0; exp_ill = 1'b0; exp_rd = '0;
      idle(2);
   endtask

   task automatic test_random;
      logic [2:0]  f3tab [10];
      logic [31:0] addr;
      f3tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
      for (int i = 0; i < 250; i++) begin
         if ($urandom_range(0, 7) == 0) addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
         else addr = 32'($urandom_range(0, 60));
         issue(1'($urandom), f3tab[$urandom_range(0, 9)], addr, $urandom);
         if ($urandom_range(0, 2) == 0) idle(1);
      end
      idle(2);
   endtask

   initial begin
      test_reset();
      test_lb_lbu();
      test_split_store();
      test_split_load();
      test_illegal();
      test_wrap();
      test_reset_mid_split();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule

// File: doc/lsu_mem_port.md
LSU_MEM_PORT -- requirements
Module: lsu_mem_port

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of request and memory port.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  load/store request present this cycle.
REQ-005 SHALL have port req_write  input  1  1=store, 0=load.
REQ-006 SHALL have port req_funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 SHALL have port req_addr  input  ADDR_W  byte address.
REQ-008 SHALL have port req_wdata  input  32  store data, LSB-aligned.
REQ-009 SHALL have port stall  output  1  request not accepted / pipeline hold.
REQ-010 SHALL have port resp_valid  output  1  one-cycle load-completion pulse.
REQ-011 SHALL have port resp_rdata  output  32  extended load result.
REQ-012 SHALL have port illegal  output  1  one-cycle pulse for an illegal request.
REQ-013 SHALL have ports mem_addr (ADDR_W), mem_write, mem_read, mem_half, mem_byte (1 each), mem_wdata (32) as outputs, and mem_rdata (32) as input, driving a byte-addressed data memory with posedge write and combinational read.

Function
REQ-014 SHALL implement FSM states IDLE and SPLIT; requests are accepted only in IDLE with req_valid=1.
REQ-015 SHALL treat an access as aligned when it is a byte access, a half access with addr[0]=0, or a word access with addr[1:0]=00.
REQ-016 SHALL, for an aligned access, drive the memory port combinationally in the acceptance cycle: mem_addr=req_addr; mem_half=1 for H/HU; mem_byte=1 for B/BU; both 0 for W; mem_write=req_write; mem_read=~req_write; mem_wdata=req_wdata.
REQ-017 SHALL never assert mem_write and mem_read in the same cycle, and SHALL drive both low when no access is issued.
REQ-018 SHALL, for a misaligned H/HU (N=2) or W (N=4) access, latch the request, issue N byte accesses on consecutive cycles k=0..N-1 (byte 0 in the acceptance cycle, the rest in SPLIT), with mem_byte=1, mem_addr=addr+k mod 2^ADDR_W, and, for stores, mem_wdata[7:0]=wdata byte k.
REQ-019 SHALL, for split loads, capture mem_rdata[7:0] of access k into result byte k.
REQ-020 SHALL assert stall combinationally in the acceptance cycle of a misaligned access and in SPLIT cycles 1..N-2, and deassert it in the last byte cycle so that a new request can be accepted in the next cycle.
REQ-021 SHALL assert resp_valid for exactly one cycle, one cycle after the final memory access of a load (latency 1 aligned, N split), with resp_rdata registered; resp_valid SHALL not pulse for stores.
REQ-022 SHALL sign-extend B from bit 7 and H from bit 15, zero-extend BU/HU, and pass W unchanged.
REQ-023 SHALL hold resp_rdata at its last value when resp_valid=0.
REQ-024 SHALL treat funct3 011/110/111, or 100/101 with req_write=1, as illegal: issue no memory access, pulse illegal one cycle later, and not pulse resp_valid.
REQ-025 SHALL ignore req_* inputs while in SPLIT.
REQ-026 SHALL allow back-to-back aligned requests every cycle with stall=0.

Reset
REQ-027 SHALL, while rst_n=0, force state=IDLE, stall=0, resp_valid=0, illegal=0, resp_rdata=0, mem_write=0 and mem_read=0, regardless of clk.
REQ-028 SHALL, on reset mid-SPLIT, abort immediately: no further byte writes issue and no resp_valid is produced for the aborted request.

Verification
REQ-029 SHALL cover: LB addr 0x0 with mem byte 0xFF -> one-cycle mem_read with mem_byte=1, next cycle resp_valid=1 and resp_rdata=0xFFFFFFFF; LBU gives 0x000000FF.
REQ-030 SHALL cover: SW 0x11223344 at addr 0x5 -> four consecutive byte writes at 0x5..0x8 with data 44,33,22,11; stall=1 for 3 cycles; no resp_valid.
REQ-031 SHALL cover: LH at addr 0x3 with bytes 0x80 at 3 and 0xFF at 4 -> two byte reads, then resp_rdata=0xFFFFFF80 one cycle after the second read.
REQ-032 SHALL cover: funct3=011 load -> mem_read and mem_write stay 0, illegal pulses one cycle, and resp_valid stays 0.
REQ-033 SHALL cover: SW at addr 0xFFFFFFFE -> byte addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
REQ-034 SHALL cover: rst_n=0 asynchronously after the 2nd byte of a split SW -> outputs go to reset values immediately, and bytes 3-4 are never written.
